// File: rtl/mc_ctrl_pkg.sv
// rtl/mc_ctrl_pkg.sv - shared encodings for the RV32I multi-cycle control sequencer
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_TRAP
    } state_e;

    typedef enum logic [3:0] {
        CL_R,
        CL_IALU,
        CL_LOAD,
        CL_STORE,
        CL_BRANCH,
        CL_JAL,
        CL_JALR,
        CL_LUI,
        CL_AUIPC
    } iclass_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I  = 3'd0;
    localparam logic [2:0] IMM_IU = 3'd1;
    localparam logic [2:0] IMM_SH = 3'd2;
    localparam logic [2:0] IMM_S  = 3'd3;
    localparam logic [2:0] IMM_B  = 3'd4;
    localparam logic [2:0] IMM_U  = 3'd5;
    localparam logic [2:0] IMM_J  = 3'd6;

    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_REL   = 2'd1;
    localparam logic [1:0] PC_JALR  = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

endpackage

// File: rtl/inst_decode.sv
// rtl/inst_decode.sv - combinational opcode/funct3 to class, immediate format and illegal flag
module inst_decode
    import mc_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    output iclass_e    class_o,
    output logic [2:0] imm_type_o,
    output logic       illegal_o
);

    always_comb begin
        class_o    = CL_R;
        imm_type_o = IMM_I;
        illegal_o  = 1'b0;
        case (opcode_i)
            OP_R:      class_o = CL_R;
            OP_IALU: begin
                class_o = CL_IALU;
                if (funct3_i == 3'b011)
                    imm_type_o = IMM_IU;
                else if (funct3_i == 3'b001 || funct3_i == 3'b101)
                    imm_type_o = IMM_SH;
            end
            OP_LOAD:   class_o = CL_LOAD;
            OP_STORE: begin
                class_o    = CL_STORE;
                imm_type_o = IMM_S;
            end
            OP_BRANCH: begin
                class_o    = CL_BRANCH;
                imm_type_o = IMM_B;
            end
            OP_JAL: begin
                class_o    = CL_JAL;
                imm_type_o = IMM_J;
            end
            OP_JALR:   class_o = CL_JALR;
            OP_LUI: begin
                class_o    = CL_LUI;
                imm_type_o = IMM_U;
            end
            OP_AUIPC: begin
                class_o    = CL_AUIPC;
                imm_type_o = IMM_U;
            end
            default:   illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle fetch/decode/exec/mem/wb sequencer with retire counter
module mc_ctrl
    import mc_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        br_taken,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        ir_en,
    output logic        pc_en,
    output logic [1:0]  pc_sel,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic [2:0]  imm_type,
    output logic        trap,
    output logic [31:0] instret
);

    state_e      state_q, state_d;
    iclass_e     class_q, class_d;
    logic [31:0] instret_q, instret_d;
    logic        retire;

    iclass_e     dec_class;
    logic [2:0]  dec_imm;
    logic        dec_illegal;
    logic        unused_inst_bits;

    assign unused_inst_bits = ^inst[31:15];

    inst_decode u_decode (
        .opcode_i   (inst[6:0]),
        .funct3_i   (inst[14:12]),
        .class_o    (dec_class),
        .imm_type_o (dec_imm),
        .illegal_o  (dec_illegal)
    );

    // Outputs decode the current state directly so reset and ack take effect in the same cycle.
    always_comb begin
        state_d  = state_q;
        class_d  = class_q;
        retire   = 1'b0;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        ir_en    = 1'b0;
        pc_en    = 1'b0;
        pc_sel   = PC_PLUS4;
        rf_we    = 1'b0;
        wb_sel   = WB_ALU;
        imm_type = IMM_I;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_en    = imem_ack;
                    if (imem_ack)
                        state_d = ST_DECODE;
                end
                ST_DECODE: begin
                    imm_type = dec_imm;
                    class_d  = dec_class;
                    state_d  = dec_illegal ? ST_TRAP : ST_EXEC;
                end
                ST_EXEC: begin
                    imm_type = dec_imm;
                    if (class_q == CL_BRANCH) begin
                        pc_en   = 1'b1;
                        pc_sel  = br_taken ? PC_REL : PC_PLUS4;
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else if (class_q == CL_LOAD || class_q == CL_STORE) begin
                        state_d = ST_MEM;
                    end else begin
                        state_d = ST_WB;
                    end
                end
                ST_MEM: begin
                    imm_type = dec_imm;
                    dmem_req = 1'b1;
                    dmem_we  = (class_q == CL_STORE);
                    if (dmem_ack) begin
                        if (class_q == CL_STORE) begin
                            pc_en   = 1'b1;
                            retire  = 1'b1;
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_WB;
                        end
                    end
                end
                ST_WB: begin
                    imm_type = dec_imm;
                    rf_we    = (inst[11:7] != 5'd0);
                    pc_en    = 1'b1;
                    retire   = 1'b1;
                    state_d  = ST_FETCH;
                    case (class_q)
                        CL_LOAD: wb_sel = WB_LOAD;
                        CL_JAL:  begin wb_sel = WB_PC4; pc_sel = PC_REL;  end
                        CL_JALR: begin wb_sel = WB_PC4; pc_sel = PC_JALR; end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign instret_d = retire ? instret_q + 32'd1 : instret_q;
    assign instret   = rst ? 32'd0 : instret_q;
    assign trap      = !rst && (state_q == ST_TRAP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            class_q   <= CL_R;
            instret_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            class_q   <= class_d;
            instret_q <= instret_d;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - self-checking bench for mc_ctrl
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst, br_taken, imem_ack, dmem_ack;
    logic [31:0] inst;
    logic        imem_req, dmem_req, dmem_we, ir_en, pc_en, rf_we, trap;
    logic [1:0]  pc_sel, wb_sel;
    logic [2:0]  imm_type;
    logic [31:0] instret;

    mc_ctrl dut (
        .clk(clk), .rst(rst), .inst(inst), .br_taken(br_taken),
        .imem_req(imem_req), .imem_ack(imem_ack),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .ir_en(ir_en), .pc_en(pc_en), .pc_sel(pc_sel), .rf_we(rf_we),
        .wb_sel(wb_sel), .imm_type(imm_type), .trap(trap), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        int          iw, dw;
        logic        br;
        int          cyc, dreq, we, rf, wb, pcs, imm;
    } vec_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc, n_ireq, n_dreq, n_rf, n_iren;
    logic        we_seen, done;
    logic [1:0]  wbv, pcs;
    logic [2:0]  immd, imm_f;
    logic [31:0] exp_ret;
    vec_t        tbl[13];
    logic [6:0]  ops[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Call at a point just after a rising edge with the sequencer in FETCH.
    task automatic run_instr(input logic [31:0] ins, input int iw, input int dw, input logic br);
        inst = ins; br_taken = br;
        cyc = 0; n_ireq = 0; n_dreq = 0; n_rf = 0; n_iren = 0;
        we_seen = 1'b0; done = 1'b0; wbv = 2'd0; pcs = 2'd3; immd = 3'd7; imm_f = 3'd0;
        while (!done && cyc < 60) begin
            cyc++;
            imem_ack = imem_req && (n_ireq == iw);
            dmem_ack = dmem_req && (n_dreq == dw);
            #1;
            if (imem_req) begin n_ireq++; imm_f = imm_f | imm_type; end
            if (dmem_req) begin n_dreq++; if (dmem_we) we_seen = 1'b1; end
            if (ir_en) n_iren++;
            if (rf_we) begin n_rf++; wbv = wb_sel; end
            if (cyc == iw + 2) immd = imm_type;
            if (pc_en) begin done = 1'b1; pcs = pc_sel; end
            @(posedge clk); #1;
        end
        imem_ack = 1'b0; dmem_ack = 1'b0;
        chk("retire_timeout", done, 1);
    endtask

    task automatic compare(input int ecyc, input int ireq, input int edreq, input int ewe,
                           input int erf, input int ewb, input int epcs, input int eimm);
        chk("cycles", cyc, ecyc);
        chk("imem_req_cycles", n_ireq, ireq);
        chk("ir_en_pulses", n_iren, 1);
        chk("imm_in_fetch", imm_f, 0);
        chk("dmem_req_cycles", n_dreq, edreq);
        chk("dmem_we", we_seen, ewe);
        chk("rf_we_pulses", n_rf, erf);
        chk("wb_sel", wbv, ewb);
        chk("pc_sel", pcs, epcs);
        chk("imm_type", immd, eimm);
        exp_ret = exp_ret + 32'd1;
        chk("instret", instret, exp_ret);
    endtask

    // Expected behaviour from the instruction-class rules, in cycle-count arithmetic.
    task automatic model(input logic [31:0] ins, input int iw, input int dw, input logic br,
                         output int ecyc, output int edreq, output int ewe, output int erf,
                         output int ewb, output int epcs, output int eimm);
        logic [6:0] op;
        logic [2:0] f3;
        logic       rd_nz;
        op = ins[6:0]; f3 = ins[14:12]; rd_nz = (ins[11:7] != 5'd0);
        ecyc = 4 + iw; edreq = 0; ewe = 0; erf = rd_nz ? 1 : 0;
        ewb = 0; epcs = 0; eimm = 0;
        case (op)
            7'b0010011: eimm = (f3 == 3'd3) ? 1 : ((f3 == 3'd1 || f3 == 3'd5) ? 2 : 0);
            7'b0000011: begin ecyc = 5 + iw + dw; edreq = dw + 1; ewb = 1; end
            7'b0100011: begin ecyc = 4 + iw + dw; edreq = dw + 1; ewe = 1; erf = 0; eimm = 3; end
            7'b1100011: begin ecyc = 3 + iw; erf = 0; epcs = br ? 1 : 0; eimm = 4; end
            7'b1101111: begin ewb = 2; epcs = 1; eimm = 6; end
            7'b1100111: begin ewb = 2; epcs = 2; end
            7'b0110111, 7'b0010111: eimm = 5;
            default: ;
        endcase
        if (erf == 0) ewb = 0;
    endtask

    initial begin
        int ecyc, edreq, ewe, erf, ewb, epcs, eimm, iw, dw;
        logic [31:0] r;
        logic        br;

        tbl[0]  = '{32'h00500093, 0, 0, 1'b0, 4, 0, 0, 1, 0, 0, 0};
        tbl[1]  = '{32'h0000A103, 0, 0, 1'b0, 5, 1, 0, 1, 1, 0, 0};
        tbl[2]  = '{32'h0020A023, 0, 0, 1'b0, 4, 1, 1, 0, 0, 0, 3};
        tbl[3]  = '{32'h0000A103, 0, 3, 1'b0, 8, 4, 0, 1, 1, 0, 0};
        tbl[4]  = '{32'h00000463, 0, 0, 1'b1, 3, 0, 0, 0, 0, 1, 4};
        tbl[5]  = '{32'h00000463, 0, 0, 1'b0, 3, 0, 0, 0, 0, 0, 4};
        tbl[6]  = '{32'h00103093, 0, 0, 1'b0, 4, 0, 0, 1, 0, 0, 1};
        tbl[7]  = '{32'h4020D093, 0, 0, 1'b0, 4, 0, 0, 1, 0, 0, 2};
        tbl[8]  = '{32'h0080006F, 0, 0, 1'b0, 4, 0, 0, 0, 0, 1, 6};
        tbl[9]  = '{32'h008000EF, 2, 0, 1'b0, 6, 0, 0, 1, 2, 1, 6};
        tbl[10] = '{32'h000100E7, 0, 0, 1'b0, 4, 0, 0, 1, 2, 2, 0};
        tbl[11] = '{32'h123452B7, 0, 0, 1'b0, 4, 0, 0, 1, 0, 0, 5};
        tbl[12] = '{32'h0000A103, 1, 2, 1'b0, 8, 3, 0, 1, 1, 0, 0};
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

        rst = 1'b1; inst = 32'd0; br_taken = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        exp_ret = 32'd0;
        @(posedge clk); @(posedge clk); #1;
        imem_ack = 1'b1; #1;
        chk("reset_outputs", {imem_req, dmem_req, dmem_we, ir_en, pc_en, pc_sel, rf_we,
                              wb_sel, imm_type, trap, instret}, 0);
        imem_ack = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; #1;
        chk("first_imem_req", imem_req, 1);
        chk("reset_instret", instret, 0);
        chk("reset_trap", trap, 0);

        for (int i = 0; i < 13; i++) begin
            run_instr(tbl[i].ins, tbl[i].iw, tbl[i].dw, tbl[i].br);
            compare(tbl[i].cyc, tbl[i].iw + 1, tbl[i].dreq, tbl[i].we, tbl[i].rf,
                    tbl[i].wb, tbl[i].pcs, tbl[i].imm);
        end

        for (int i = 0; i < 60; i++) begin
            r  = $urandom();
            r  = {r[31:7], ops[$urandom_range(0, 8)]};
            iw = $urandom_range(0, 3);
            dw = $urandom_range(0, 3);
            br = 1'($urandom_range(0, 1));
            model(r, iw, dw, br, ecyc, edreq, ewe, erf, ewb, epcs, eimm);
            run_instr(r, iw, dw, br);
            compare(ecyc, iw + 1, edreq, ewe, erf, ewb, epcs, eimm);
        end

        // Illegal opcode: sticky trap, acks ignored, reset recovers.
        inst = 32'h0000007F;
        imem_ack = 1'b1; #1;
        chk("trap_ir_en", ir_en, 1);
        @(posedge clk); #1; imem_ack = 1'b0;
        @(posedge clk); #1;
        chk("trap_set", trap, 1);
        imem_ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("trap_sticky", {trap, imem_req, ir_en, pc_en, rf_we, dmem_req}, 6'b100000);
            @(posedge clk); #1;
        end
        imem_ack = 1'b0;
        rst = 1'b1; #1;
        chk("trap_in_reset", trap, 0);
        @(posedge clk); #1;
        rst = 1'b0; #1;
        chk("trap_cleared", {trap, imem_req}, 2'b01);
        exp_ret = 32'd0;
        chk("instret_after_reset", instret, 0);

        // Reset while a load is waiting in MEM; the late ack must be ignored.
        inst = 32'h0000A103;
        imem_ack = 1'b1;
        @(posedge clk); #1; imem_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("mem_req_before_rst", dmem_req, 1);
        rst = 1'b1; #1;
        chk("mem_req_in_rst", {dmem_req, imem_req, rf_we, pc_en}, 0);
        @(posedge clk); #1;
        rst = 1'b0; dmem_ack = 1'b1; #1;
        chk("late_ack_ignored", {dmem_req, imem_req, rf_we, pc_en, ir_en}, 5'b01000);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        chk("late_ack_instret", instret, 0);
        run_instr(32'h00500093, 0, 0, 1'b0);
        compare(4, 1, 0, 0, 1, 0, 0, 0);

        // Counter wrap.
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        chk("instret_forced", instret, 32'hFFFF_FFFF);
        exp_ret = 32'hFFFF_FFFF;
        run_instr(32'h00500093, 0, 0, 1'b0);
        compare(4, 1, 0, 0, 1, 0, 0, 0);
        chk("instret_wrap", instret, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
